// File: rtl/lcd_pixel_fetch.sv
// Frame-buffer pixel fetcher: follows de_in, reads a 1-cycle-latency RAM and drives RGB565 to the panel
// with DE aligned two cycles behind de_in. Also provides colour bars, frame_done and a sticky row error.
module lcd_pixel_fetch #(
  parameter int H_ACTIVE = 5,
  parameter int V_ACTIVE = 10,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              de_in,
  input  logic              test_pattern,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              pix_de,
  output logic [15:0]       pix_data,
  output logic              frame_done,
  output logic              row_err
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ROW, ACTIVE_ROW, ROW_END} state_t;

  state_t            state, state_next;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              in_row;
  logic              row_end;
  logic [2:0]        bar_idx;
  logic [ADDR_W-1:0] next_row_addr;

  logic              valid1;
  logic              rd1;
  logic              tp1;
  logic [2:0]        bar1;

  assign mem_addr      = addr;
  assign bar_idx       = 3'((32'(x) * 32'd8) / 32'(H_ACTIVE));
  assign next_row_addr = ADDR_W'((32'(y) + 32'd1) * 32'(H_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // de_in is only honoured once the FSM has left IDLE, so a strobe coinciding with en rising is dropped
  always_comb begin
    state_next = state;
    in_row     = 1'b0;
    row_end    = 1'b0;
    mem_rd     = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE:       state_next = WAIT_ROW;
      WAIT_ROW:   if (de_in) state_next = ACTIVE_ROW;
      ACTIVE_ROW: if (!de_in) state_next = ROW_END;
      ROW_END:    state_next = WAIT_ROW;
    endcase
    if (!en) state_next = IDLE;
    in_row     = en && de_in && (state == WAIT_ROW || state == ACTIVE_ROW);
    row_end    = en && (state == ROW_END);
    mem_rd     = in_row && (x < X_END);
    frame_done = row_end && (y == Y_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      addr    <= '0;
      row_err <= 1'b0;
    end else if (!en) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else begin
      if (in_row) begin
        if (mem_rd) begin
          x    <= x + XW'(1);
          addr <= addr + ADDR_W'(1);
        end else begin
          row_err <= 1'b1;
        end
      end
      // Re-deriving the row base keeps short rows from skewing every following row
      if (row_end) begin
        x <= '0;
        if (x != X_END) row_err <= 1'b1;
        if (y == Y_LAST) begin
          y    <= '0;
          addr <= '0;
        end else begin
          y    <= y + YW'(1);
          addr <= next_row_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1   <= 1'b0;
      rd1      <= 1'b0;
      tp1      <= 1'b0;
      bar1     <= '0;
      pix_de   <= 1'b0;
      pix_data <= '0;
    end else if (!en) begin
      valid1   <= 1'b0;
      rd1      <= 1'b0;
      tp1      <= 1'b0;
      bar1     <= '0;
      pix_de   <= 1'b0;
      pix_data <= '0;
    end else begin
      valid1 <= in_row;
      rd1    <= mem_rd;
      tp1    <= test_pattern;
      bar1   <= bar_idx;
      pix_de <= valid1;
      if (valid1 && rd1)
        pix_data <= tp1 ? {{5{bar1[2]}}, {6{bar1[1]}}, {5{bar1[0]}}} : mem_rdata;
      else
        pix_data <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_fetch.sv
// Self-checking bench for lcd_pixel_fetch: a row-level expectation model indexed by cycle number,
// compared against the DUT every cycle, plus literal pins on selected pixels and addresses.
module tb_lcd_pixel_fetch;

  localparam int H  = 5;
  localparam int V  = 10;
  localparam int AW = 6;
  localparam int NC = 4096;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          de_in = 1'b0;
  logic          test_pattern = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata = 16'h0000;
  logic          pix_de;
  logic [15:0]   pix_data;
  logic          frame_done;
  logic          row_err;

  lcd_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .de_in(de_in), .test_pattern(test_pattern),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_de(pix_de), .pix_data(pix_data), .frame_done(frame_done), .row_err(row_err)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:63];
  always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          exp_rd   [NC];
  logic [AW-1:0] exp_addr [NC];
  logic          exp_fd   [NC];
  logic          exp_pde  [NC];
  logic [15:0]   exp_pd   [NC];
  logic [15:0]   obs_pd   [NC];
  logic [AW-1:0] obs_addr [NC];
  int err_from = NEVER;
  bit chk_en = 1'b0;
  int m_row = 0;
  int cur = 0;
  int row_start = 0;
  int nvec = 0;
  int nmis = 0;
  int fd_count = 0;
  logic [15:0] bars [5];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    nvec++;
    if (act !== expv) begin
      nmis++;
      $display("[TB] FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [15:0] model_pix(input int idx, input bit tp, input int col);
    int b;
    logic [15:0] v;
    if (!tp) return ram[idx];
    b = (col * 8) / H;
    v = 16'h0000;
    if (b[2]) v = v | 16'hF800;
    if (b[1]) v = v | 16'h07E0;
    if (b[0]) v = v | 16'h001F;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en && cyc < NC) begin
      obs_pd[cyc]   = pix_data;
      obs_addr[cyc] = mem_addr;
      if (frame_done) fd_count++;
      checkOutput("mem_rd", 16'(mem_rd), 16'(exp_rd[cyc]));
      if (exp_rd[cyc]) checkOutput("mem_addr", 16'(mem_addr), 16'(exp_addr[cyc]));
      checkOutput("frame_done", 16'(frame_done), 16'(exp_fd[cyc]));
      checkOutput("pix_de", 16'(pix_de), 16'(exp_pde[cyc]));
      checkOutput("pix_data", pix_data, exp_pd[cyc]);
      checkOutput("row_err", 16'(row_err), 16'(cyc >= err_from));
    end
  end

  task automatic tick(input bit e, input bit d, input bit t);
    @(posedge clk);
    #1;
    en = e;
    de_in = d;
    test_pattern = t;
    cur = cyc;
  endtask

  task automatic fetch_px(input int col, input bit tp);
    tick(1'b1, 1'b1, tp);
    if (col == 0) row_start = cur;
    if (col < H) begin
      exp_rd[cur]   = 1'b1;
      exp_addr[cur] = AW'(m_row * H + col);
      exp_pde[cur+2] = 1'b1;
      exp_pd[cur+2]  = model_pix(m_row * H + col, tp, col);
    end else begin
      exp_pde[cur+2] = 1'b1;
      exp_pd[cur+2]  = 16'h0000;
      if (cur + 1 < err_from) err_from = cur + 1;
    end
  endtask

  // One row of len de_in cycles followed by gap quiet cycles
  task automatic applyStimulus(input int len, input int tp_mask, input int gap);
    int last;
    for (int i = 0; i < len; i++) fetch_px(i, tp_mask[i]);
    last = cur;
    if (len < H && last + 3 < err_from) err_from = last + 3;
    if (m_row == V - 1) exp_fd[last+2] = 1'b1;
    m_row = (m_row + 1) % V;
    for (int g = 0; g < gap; g++) tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic en_low(input int n, input bit d);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, d, 1'b0);
      exp_pde[cur+1] = 1'b0;
      exp_pd[cur+1]  = 16'h0000;
    end
    m_row = 0;
  endtask

  initial begin
    int pin_cycle;
    for (int i = 0; i < 64; i++) ram[i] = 16'(i) ^ 16'h5A00;
    for (int i = 0; i < NC; i++) begin
      exp_rd[i] = 1'b0; exp_addr[i] = '0; exp_fd[i] = 1'b0;
      exp_pde[i] = 1'b0; exp_pd[i] = 16'h0000; obs_pd[i] = 16'h0000; obs_addr[i] = '0;
    end
    bars[0] = 16'h0000; bars[1] = 16'h001F; bars[2] = 16'h07FF; bars[3] = 16'hF800; bars[4] = 16'hFFE0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_mem_rd", 16'(mem_rd), 16'h0);
    checkOutput("reset_mem_addr", 16'(mem_addr), 16'h0);
    checkOutput("reset_pix_de", 16'(pix_de), 16'h0);
    checkOutput("reset_pix_data", pix_data, 16'h0);
    checkOutput("reset_frame_done", 16'(frame_done), 16'h0);
    checkOutput("reset_row_err", 16'(row_err), 16'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);

    $display("[TB] full frame from RAM");
    for (int r = 0; r < V; r++) applyStimulus(5, 0, 3);
    pin_cycle = cur - 3;
    checkOutput("frame_done_count", 16'(fd_count), 16'd1);
    checkOutput("last_pixel", obs_pd[pin_cycle+2], 16'h5A31);

    $display("[TB] colour bars and mid-row pattern switch");
    applyStimulus(5, 5'b11111, 3);
    for (int i = 0; i < 5; i++) checkOutput("bar_pixel", obs_pd[row_start+2+i], bars[i]);

    $display("[TB] long and short rows");
    applyStimulus(7, 0, 3);
    applyStimulus(3, 0, 3);
    applyStimulus(5, 5'b00110, 3);
    checkOutput("addr_after_short", 16'(obs_addr[row_start]), 16'd15);

    $display("[TB] enable drop mid-row");
    fetch_px(0, 1'b0);
    fetch_px(1, 1'b0);
    en_low(3, 1'b1);
    en_low(2, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    applyStimulus(5, 0, 3);
    checkOutput("addr_after_en_drop", 16'(obs_addr[row_start]), 16'd0);

    $display("[TB] de_in coinciding with enable rise");
    en_low(2, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    applyStimulus(5, 0, 3);

    $display("[TB] async reset mid-row");
    fetch_px(0, 1'b0);
    fetch_px(1, 1'b0);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    cur = cyc;
    de_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_mem_rd", 16'(mem_rd), 16'h0);
    checkOutput("async_mem_addr", 16'(mem_addr), 16'h0);
    checkOutput("async_pix_de", 16'(pix_de), 16'h0);
    checkOutput("async_pix_data", pix_data, 16'h0);
    checkOutput("async_frame_done", 16'(frame_done), 16'h0);
    checkOutput("async_row_err", 16'(row_err), 16'h0);
    for (int i = cur; i < cur + 4; i++) begin
      exp_rd[i] = 1'b0; exp_fd[i] = 1'b0; exp_pde[i] = 1'b0; exp_pd[i] = 16'h0000;
    end
    err_from = NEVER;
    m_row = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    de_in = 1'b0;
    en = 1'b1;
    chk_en = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    applyStimulus(5, 0, 3);
    checkOutput("addr_after_reset", 16'(obs_addr[row_start]), 16'd0);
    applyStimulus(5, 0, 3);
    repeat (3) tick(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
